// File: rtl/sdm_ratio_meas.sv
// sdm_ratio_meas: recovers the programmed fractional-N ratio N.frac from the
// per-divider-cycle modulus stream of the sigma-delta modulator by summing a
// power-of-two number of samples and reading the sum as a fixed-point value.
// Window length is 2^(FRAC_W+win_sel) samples, latched when a run starts.
// Optional feature: define SDM_RATIO_MEAS_RANGE_CHK_EN to add min/max tracking
// of the accepted modulus values and a spread error flag.
module sdm_ratio_meas #(
    parameter int MPR_W  = 6,
    parameter int FRAC_W = 10,
    parameter int WSEL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WSEL_W-1:0] win_sel,
    input  logic [MPR_W-1:0]  mpr_i,
    input  logic              mpr_vld,
    output logic              busy,
    output logic              done,
    output logic [MPR_W-1:0]  n_o,
    output logic [FRAC_W-1:0] frac_o
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
    ,
    output logic [MPR_W-1:0]  mpr_min_o,
    output logic [MPR_W-1:0]  mpr_max_o,
    output logic              range_err
`endif
);

    // Largest window exponent offset; sizes the sum and the sample counter.
    localparam int WS_MAX = (1 << WSEL_W) - 1;
    // Sum of 2^(FRAC_W+WS_MAX) samples of MPR_W bits cannot exceed this width.
    localparam int ACC_W  = MPR_W + FRAC_W + WS_MAX;
    // The counter wraps to zero on the final sample of the longest window,
    // so the terminal test compares against window length minus one.
    localparam int CNT_W  = FRAC_W + WS_MAX;

    localparam logic [CNT_W:0] WIN_ONE = {{CNT_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [WSEL_W-1:0]   ws_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W:0]      win_len;
    logic                last_sample;
    logic                busy_q;
    logic                done_q;
    logic [MPR_W-1:0]    n_q;
    logic [MPR_W-1:0]    n_d;
    logic [FRAC_W-1:0]   frac_q;
    logic [FRAC_W-1:0]   frac_d;

    // Next-value datapath: running sum, sample count, end-of-window detect and
    // the truncated integer/fraction fields of the sum including this sample.
    always_comb begin
        // NOTE: every signal of this block is assigned unconditionally first,
        // so no path through it can leave a value held and infer a latch.
        acc_d       = acc_q + ACC_W'(mpr_i);
        cnt_d       = cnt_q + CNT_W'(1);
        win_len     = WIN_ONE << (FRAC_W + int'(ws_q));
        last_sample = mpr_vld && (cnt_q == CNT_W'(win_len - WIN_ONE));
        // Binary point of the sum sits FRAC_W+ws bits up; drop the low ws bits.
        n_d         = MPR_W'(acc_d >> (FRAC_W + int'(ws_q)));
        frac_d      = FRAC_W'(acc_d >> ws_q);
    end

    // Measurement sequencer with registered busy/done and result outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            ws_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= '0;
            frac_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort carries no meaning here, so start always wins.
                    if (start) begin
                        state_q <= S_ACQ;
                        busy_q  <= 1'b1;
                        ws_q    <= win_sel;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_ACQ: begin
                    // abort outranks a simultaneous final sample; results hold.
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (mpr_vld) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (last_sample) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            n_q     <= n_d;
                            frac_q  <= frac_d;
                        end
                    end
                end
                S_DONE: begin
                    // Single-cycle result strobe; start and abort are ignored.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign n_o    = n_q;
    assign frac_o = frac_q;

`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
    // A MASH-1-1-1 modulator never spreads the modulus by more than 7.
    localparam logic [MPR_W-1:0] SPREAD_MAX = MPR_W'(7);

    logic [MPR_W-1:0] min_q;
    logic [MPR_W-1:0] min_d;
    logic [MPR_W-1:0] max_q;
    logic [MPR_W-1:0] max_d;
    logic [MPR_W-1:0] spread_d;
    logic [MPR_W-1:0] mpr_min_q;
    logic [MPR_W-1:0] mpr_max_q;
    logic             range_err_q;

    // Running extremes including the current sample, and their spread.
    always_comb begin
        min_d    = (mpr_i < min_q) ? mpr_i : min_q;
        max_d    = (mpr_i > max_q) ? mpr_i : max_q;
        spread_d = max_d - min_d;
    end

    // Track extremes of accepted samples; publish them with the ratio result.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_q       <= '0;
            max_q       <= '0;
            mpr_min_q   <= '0;
            mpr_max_q   <= '0;
            range_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        min_q <= '1;
                        max_q <= '0;
                    end
                end
                S_ACQ: begin
                    if (!abort && mpr_vld) begin
                        min_q <= min_d;
                        max_q <= max_d;
                        if (last_sample) begin
                            mpr_min_q   <= min_d;
                            mpr_max_q   <= max_d;
                            range_err_q <= (spread_d > SPREAD_MAX);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mpr_min_o = mpr_min_q;
    assign mpr_max_o = mpr_max_q;
    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_sdm_ratio_meas.sv
// tb_sdm_ratio_meas: directed self-checking bench for sdm_ratio_meas.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_sdm_ratio_meas;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] win_sel;
    logic [5:0] mpr_i;
    logic       mpr_vld;
    logic       busy;
    logic       done;
    logic [5:0] n_o;
    logic [9:0] frac_o;
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
    logic [5:0] mpr_min_o;
    logic [5:0] mpr_max_o;
    logic       range_err;
`endif

    int total = 0;
    int bad   = 0;

    // Free-running event counters, sampled mid-cycle.
    int done_seen = 0;
    int busy_seen = 0;

    int d0;
    int b0;
    int mn;
    int mx;
    int val;
    int a1, a2, a3, c1, c2, c3, c2p, c3p, c3pp, y;

    sdm_ratio_meas #(
        .MPR_W (6),
        .FRAC_W(10),
        .WSEL_W(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .win_sel  (win_sel),
        .mpr_i    (mpr_i),
        .mpr_vld  (mpr_vld),
        .busy     (busy),
        .done     (done),
        .n_o      (n_o),
        .frac_o   (frac_o)
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
        ,
        .mpr_min_o(mpr_min_o),
        .mpr_max_o(mpr_max_o),
        .range_err(range_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic vld, input int v, input logic st, input logic ab);
        mpr_vld = vld;
        mpr_i   = 6'(v);
        start   = st;
        abort   = ab;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_sel = 2'd0;
        mpr_i = 6'd0; mpr_vld = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_n",    32'(n_o),  32'd0);
        check("rst_frac", 32'(frac_o), 32'd0);
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
        check("rst_min", 32'(mpr_min_o), 32'd0);
        check("rst_max", 32'(mpr_max_o), 32'd0);
        check("rst_err", 32'(range_err), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // ---- T1: 1024 x 31, ws=0, busy length, start in DONE ignored ----
        d0 = done_seen;
        b0 = busy_seen;
        win_sel = 2'd0;
        drive(1'b0, 0, 1'b1, 1'b0);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 1024; i++) drive(1'b1, 31, 1'b0, 1'b0);
        check("t1_no_early_done", 32'(done_seen - d0), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_busy_cycles", 32'(busy_seen - b0), 32'd1024);
        check("t1_n", 32'(n_o), 32'd31);
        check("t1_frac", 32'(frac_o), 32'd0);
        drive(1'b0, 0, 1'b1, 1'b0);
        check("t1_start_in_done_ignored", 32'(busy), 32'd0);
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_done_count", 32'(done_seen - d0), 32'd1);

        // ---- T3: MASH-1-1-1 stream N=31 frac=416, ws=3; win_sel moved mid-run ----
        d0 = done_seen;
        a1 = 0; a2 = 0; a3 = 0; c2p = 0; c3p = 0; c3pp = 0;
        mn = 63; mx = 0;
        win_sel = 2'd3;
        drive(1'b0, 0, 1'b1, 1'b0);
        win_sel = 2'd0;
        for (int i = 0; i < 8192; i++) begin
            a1 = a1 + 416; c1 = a1 >> 10; a1 = a1 & 1023;
            a2 = a2 + a1;  c2 = a2 >> 10; a2 = a2 & 1023;
            a3 = a3 + a2;  c3 = a3 >> 10; a3 = a3 & 1023;
            y = c1 + c2 - c2p + c3 - 2 * c3p + c3pp;
            c3pp = c3p; c3p = c3; c2p = c2;
            val = 31 + y;
            if (val < mn) mn = val;
            if (val > mx) mx = val;
            drive(1'b1, val, 1'b0, 1'b0);
        end
        check("t3_no_early_done", 32'(done_seen - d0), 32'd0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_n", 32'(n_o), 32'd31);
        check("t3_frac_in_415_417", 32'(frac_o >= 10'd415 && frac_o <= 10'd417), 32'd1);
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
        check("t3_min", 32'(mpr_min_o), 32'(mn));
        check("t3_max", 32'(mpr_max_o), 32'(mx));
        check("t3_spread_le_7", 32'((mpr_max_o - mpr_min_o) <= 6'd7), 32'd1);
        check("t3_range_err", 32'(range_err), 32'd0);
`endif
        drive(1'b0, 0, 1'b0, 1'b0);

        // ---- T2: alternating 31/32 with mpr_vld toggling; garbage on gaps ----
        d0 = done_seen;
        win_sel = 2'd0;
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 2047; k++) begin
            if (k % 2 == 0) drive(1'b1, ((k / 2) % 2 == 0) ? 31 : 32, 1'b0, 1'b0);
            else            drive(1'b0, 63, 1'b0, 1'b0);
        end
        check("t2_no_early_done", 32'(done_seen - d0), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_n", 32'(n_o), 32'd31);
        check("t2_frac", 32'(frac_o), 32'd512);
        drive(1'b0, 0, 1'b0, 1'b0);
        check("t2_done_drop", 32'(done), 32'd0);

        // ---- T4: abort with a valid sample after 500 samples ----
        d0 = done_seen;
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 500; i++) drive(1'b1, 40, 1'b0, 1'b0);
        drive(1'b1, 40, 1'b0, 1'b1);
        check("t4_abort_busy", 32'(busy), 32'd0);
        check("t4_abort_done", 32'(done), 32'd0);
        check("t4_abort_n_hold", 32'(n_o), 32'd31);
        check("t4_abort_frac_hold", 32'(frac_o), 32'd512);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        check("t4_abort_no_done", 32'(done_seen - d0), 32'd0);

        // ---- T4b: abort on the same cycle as the final sample ----
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 1023; i++) drive(1'b1, 40, 1'b0, 1'b0);
        drive(1'b1, 40, 1'b0, 1'b1);
        check("t4b_final_abort_done", 32'(done), 32'd0);
        check("t4b_final_abort_busy", 32'(busy), 32'd0);
        check("t4b_final_abort_n", 32'(n_o), 32'd31);
        drive(1'b0, 0, 1'b0, 1'b0);
        check("t4b_no_done", 32'(done_seen - d0), 32'd0);

        // ---- T4c: start+abort in IDLE starts; later win_sel change ignored ----
        drive(1'b0, 0, 1'b1, 1'b1);
        check("t4c_start_wins", 32'(busy), 32'd1);
        win_sel = 2'd2;
        for (int i = 0; i < 1024; i++) drive(1'b1, 5, 1'b0, 1'b0);
        check("t4c_done", 32'(done), 32'd1);
        check("t4c_n", 32'(n_o), 32'd5);
        check("t4c_frac", 32'(frac_o), 32'd0);
        win_sel = 2'd0;
        drive(1'b0, 0, 1'b0, 1'b0);

        // ---- T5: reset mid-ACQ, then a run with start pulses ignored ----
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 20, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 20, 1'b0, 1'b0);
        rst = 1'b0;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_n", 32'(n_o), 32'd0);
        check("t5_rst_frac", 32'(frac_o), 32'd0);
        d0 = done_seen;
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 1024; i++) drive(1'b1, 40, (i == 100 || i == 500), 1'b0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_n", 32'(n_o), 32'd40);
        check("t5_frac", 32'(frac_o), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        check("t5_single_done", 32'(done_seen - d0), 32'd1);
        check("t5_idle_after", 32'(busy), 32'd0);

        // ---- T6: 1023 x 31 plus one 45 ----
        drive(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 1023; i++) drive(1'b1, 31, 1'b0, 1'b0);
        drive(1'b1, 45, 1'b0, 1'b0);
        check("t6_done", 32'(done), 32'd1);
        check("t6_n", 32'(n_o), 32'd31);
        check("t6_frac", 32'(frac_o), 32'd14);
`ifdef SDM_RATIO_MEAS_RANGE_CHK_EN
        check("t6_min", 32'(mpr_min_o), 32'd31);
        check("t6_max", 32'(mpr_max_o), 32'd45);
        check("t6_range_err", 32'(range_err), 32'd1);
`endif
        drive(1'b0, 0, 1'b0, 1'b0);
        check("t6_hold_n", 32'(n_o), 32'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
